// File: rtl/spi_sync_frontend.sv
// SPI mode-0 slave pin front end: synchronises SCK/MOSI/CS, glitch-filters CS,
// deserialises MOSI into bytes and serialises the response byte onto MISO.
//   state  | meaning
//   IDLE   | no transaction; SCK edges ignored, MISO held low
//   ACTIVE | filtered CS low; shifting bits on SCK edges
module spi_sync_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int CS_FILTER   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       cs_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       frame_err,
  output logic       tx_req,
  input  logic [7:0] tx_data
);
  localparam int CNT_W = (CS_FILTER > 1) ? $clog2(CS_FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CS_FILTER - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, fill_q;
  logic                   sck_d1_q;
  logic                   sck_s, mosi_s, cs_s, samp_ok, sck_rise, sck_fall;

  logic [CNT_W-1:0] cs_cnt_q, cs_cnt_d;
  logic             cs_filt_q, cs_filt_d;
  logic             armed_q, armed_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        first_q, first_d;
  logic        rise_seen_q, rise_seen_d;
  logic        load_q, load_d;
  logic        byte_done_q, byte_done_d;
  logic        miso_q, miso_d;
  logic        tx_req_q, tx_req_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_first_q, rx_first_d;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign samp_ok  = fill_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d1_q;
  assign sck_fall = ~sck_s & sck_d1_q;

  // fill_q marks when the CS chain holds real pin samples rather than reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      fill_q      <= '0;
      sck_d1_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_d1_q    <= sck_s;
    end
  end

  // Filtered CS starts low so that only a confirmed-high CS can arm the link
  always_comb begin
    cs_cnt_d  = cs_cnt_q;
    cs_filt_d = cs_filt_q;
    armed_d   = armed_q | cs_filt_q;
    if (!samp_ok || cs_s == cs_filt_q) begin
      cs_cnt_d = '0;
    end else if (cs_cnt_q == CNT_LAST) begin
      cs_filt_d = cs_s;
      cs_cnt_d  = '0;
    end else begin
      cs_cnt_d = cs_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    first_d     = first_q;
    rise_seen_d = rise_seen_q;
    load_d      = 1'b0;
    byte_done_d = 1'b0;
    tx_req_d    = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    rx_valid_d  = byte_done_q;
    rx_first_d  = byte_done_q & first_q;
    rx_data_d   = byte_done_q ? rx_shift_q : rx_data_q;
    if (byte_done_q) first_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && !cs_filt_q) begin
          state_d     = ACTIVE;
          bit_cnt_d   = 3'd0;
          first_d     = 1'b1;
          rise_seen_d = 1'b0;
          tx_shift_d  = 8'h00;
          tx_req_d    = 1'b1;
          load_d      = 1'b1;
        end
      end
      ACTIVE: begin
        miso_d = tx_shift_q[7];
        if (cs_filt_q) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
        end else begin
          if (load_q) tx_shift_d = tx_data;
          if (sck_rise) begin
            rx_shift_d  = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            rise_seen_d = 1'b1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              tx_req_d    = 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
            else if (rise_seen_q)  tx_shift_d = tx_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_cnt_q    <= '0;
      cs_filt_q   <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      first_q     <= 1'b0;
      rise_seen_q <= 1'b0;
      load_q      <= 1'b0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b0;
      tx_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
    end else begin
      cs_cnt_q    <= cs_cnt_d;
      cs_filt_q   <= cs_filt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      first_q     <= first_d;
      rise_seen_q <= rise_seen_d;
      load_q      <= load_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      tx_req_q    <= tx_req_d;
      frame_err_q <= frame_err_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
    end
  end

  assign spi_miso  = miso_q;
  assign cs_active = (state_q == ACTIVE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_first  = rx_first_q;
  assign frame_err = frame_err_q;
  assign tx_req    = tx_req_q;

endmodule
